// File: rtl/lru_buffer_param.sv
// lru_buffer_param: per-set true-LRU age and valid state for a WAYS-way, SETS-set cache.
// Handles hit-promote, miss-allocate and invalidate; reports victim way and pre-update ages.
module lru_buffer_param #(
  parameter  int WAYS  = 8,
  parameter  int SETS  = 128,
  parameter  int CNT_W = 32,
  localparam int AGE_W = $clog2(WAYS),
  localparam int AW    = $clog2(SETS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_op,
  input  logic [AW-1:0]          i_addr,
  input  logic [WAYS-1:0]        i_hit_way,
  input  logic                   i_cnt_clr,
  output logic                   o_valid,
  output logic [WAYS-1:0]        o_victim_way,
  output logic [WAYS*AGE_W-1:0]  o_age_vec,
  output logic                   o_err,
  output logic [CNT_W-1:0]       o_hit_cnt,
  output logic [CNT_W-1:0]       o_miss_cnt
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_HIT  = 2'd1,
    OP_FILL = 2'd2,
    OP_INV  = 2'd3
  } op_e;

  logic [WAYS*AGE_W-1:0] r_age [SETS];
  logic [WAYS-1:0]       r_vld [SETS];

  logic                  r_valid;
  logic                  r_err;
  logic [WAYS-1:0]       r_victim;
  logic [WAYS*AGE_W-1:0] r_age_out;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [CNT_W-1:0]      r_miss_cnt;

  op_e                   w_op;
  logic [WAYS*AGE_W-1:0] w_age_cur;
  logic [WAYS-1:0]       w_vld_cur;
  logic                  w_hit_onehot;
  logic [AGE_W-1:0]      w_hit_idx;
  logic [AGE_W-1:0]      w_vic_idx;
  logic                  w_has_free;
  logic [WAYS*AGE_W-1:0] w_new_age;
  logic [WAYS-1:0]       w_new_vld;
  logic [WAYS-1:0]       w_victim_oh;
  logic                  w_upd;
  logic                  w_err;
  logic                  w_hit_inc;
  logic                  w_miss_inc;

  assign w_op      = op_e'(i_op);
  assign w_age_cur = r_age[i_addr];
  assign w_vld_cur = r_vld[i_addr];

  // Move way p to MRU; every way younger than p ages by one.
  function automatic logic [WAYS*AGE_W-1:0] f_promote(input logic [WAYS*AGE_W-1:0] ages,
                                                      input logic [AGE_W-1:0] p);
    logic [AGE_W-1:0] a;
    a = '0;
    for (int w = 0; w < WAYS; w++)
      if (AGE_W'(w) == p) a = ages[w*AGE_W +: AGE_W];
    f_promote = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == p)
        f_promote[w*AGE_W +: AGE_W] = '0;
      else if (ages[w*AGE_W +: AGE_W] < a)
        f_promote[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] + AGE_W'(1);
    end
  endfunction

  // Move way p to LRU; every way older than p gets one step younger.
  function automatic logic [WAYS*AGE_W-1:0] f_retire(input logic [WAYS*AGE_W-1:0] ages,
                                                     input logic [AGE_W-1:0] p);
    logic [AGE_W-1:0] a;
    a = '0;
    for (int w = 0; w < WAYS; w++)
      if (AGE_W'(w) == p) a = ages[w*AGE_W +: AGE_W];
    f_retire = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == p)
        f_retire[w*AGE_W +: AGE_W] = AGE_W'(WAYS-1);
      else if (ages[w*AGE_W +: AGE_W] > a)
        f_retire[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] - AGE_W'(1);
    end
  endfunction

  // Decode the hit way and pick the allocation victim (lowest invalid way, else the LRU way).
  always_comb begin
    w_hit_onehot = $onehot(i_hit_way);
    w_hit_idx    = '0;
    w_vic_idx    = '0;
    w_has_free   = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (i_hit_way[w]) w_hit_idx = AGE_W'(w);
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!w_vld_cur[w]) begin
        w_vic_idx  = AGE_W'(w);
        w_has_free = 1'b1;
      end
    end
    if (!w_has_free) begin
      for (int w = 0; w < WAYS; w++)
        if (w_age_cur[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1)) w_vic_idx = AGE_W'(w);
    end
  end

  // Compute the next state of the addressed set and the response for the current op.
  always_comb begin
    w_new_age   = w_age_cur;
    w_new_vld   = w_vld_cur;
    w_victim_oh = '0;
    w_upd       = 1'b0;
    w_err       = 1'b0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    case (w_op)
      OP_HIT: begin
        if (!w_hit_onehot || ((w_vld_cur & i_hit_way) == '0)) begin
          w_err = 1'b1;
        end else begin
          w_new_age   = f_promote(w_age_cur, w_hit_idx);
          w_victim_oh = i_hit_way;
          w_upd       = 1'b1;
          w_hit_inc   = 1'b1;
        end
      end
      OP_FILL: begin
        w_new_age              = f_promote(w_age_cur, w_vic_idx);
        w_new_vld[w_vic_idx]   = 1'b1;
        w_victim_oh[w_vic_idx] = 1'b1;
        w_upd                  = 1'b1;
        w_miss_inc             = 1'b1;
      end
      OP_INV: begin
        if (!w_hit_onehot) begin
          w_err = 1'b1;
        end else begin
          w_new_age            = f_retire(w_age_cur, w_hit_idx);
          w_new_vld[w_hit_idx] = 1'b0;
          w_upd                = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Set state and response registers; reset restores ordered ages and clears valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++)
          r_age[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
        r_vld[s] <= '0;
      end
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_victim  <= '0;
      r_age_out <= '0;
    end else begin
      if (w_upd) begin
        r_age[i_addr] <= w_new_age;
        r_vld[i_addr] <= w_new_vld;
      end
      r_valid <= (w_op != OP_NOP);
      r_err   <= w_err;
      if (w_op != OP_NOP) begin
        r_victim  <= w_victim_oh;
        r_age_out <= w_age_cur;
      end
    end
  end

  // Saturating hit/miss counters; clear wins over increment and works regardless of reset.
  always_ff @(posedge clk) begin
    if (i_cnt_clr || rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc && !(&r_hit_cnt))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (w_miss_inc && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign o_valid      = r_valid;
  assign o_err        = r_err;
  assign o_victim_way = r_victim;
  assign o_age_vec    = r_age_out;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_lru_buffer_param.sv
// tb_lru_buffer_param: directed and randomized checks of lru_buffer_param against a recency-list model.
module tb_lru_buffer_param;

  localparam logic [1:0] NOP = 2'd0, HIT = 2'd1, FILL = 2'd2, INV = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  opIn;
  logic [6:0]  addrIn;
  logic [7:0]  hitWayIn;
  logic        cntClrIn;
  logic        validOut;
  logic [7:0]  victimOut;
  logic [23:0] ageVecOut;
  logic        errOut;
  logic [31:0] hitCntOut;
  logic [31:0] missCntOut;

  logic [1:0]  sOp;
  logic [3:0]  sAddr;
  logic [3:0]  sHitWay;
  logic        sCntClr;
  logic        sValid;
  logic [3:0]  sVictim;
  logic [7:0]  sAgeVec;
  logic        sErr;
  logic [3:0]  sHitCnt;
  logic [3:0]  sMissCnt;

  int checks = 0;
  int errors = 0;

  // Model: ord[s][k] is the way currently holding age k (recency list, MRU first).
  int          ord [128][8];
  bit          mVld [128][8];
  longint      mHit, mMiss;
  logic        expValid, expErr;
  logic [7:0]  expVictim;
  logic [23:0] expAge;

  lru_buffer_param dut (
    .clk(clk), .rst(rst), .i_op(opIn), .i_addr(addrIn), .i_hit_way(hitWayIn),
    .i_cnt_clr(cntClrIn), .o_valid(validOut), .o_victim_way(victimOut),
    .o_age_vec(ageVecOut), .o_err(errOut), .o_hit_cnt(hitCntOut), .o_miss_cnt(missCntOut)
  );

  lru_buffer_param #(.WAYS(4), .SETS(16), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .i_op(sOp), .i_addr(sAddr), .i_hit_way(sHitWay),
    .i_cnt_clr(sCntClr), .o_valid(sValid), .o_victim_way(sVictim),
    .o_age_vec(sAgeVec), .o_err(sErr), .o_hit_cnt(sHitCnt), .o_miss_cnt(sMissCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic void resetModel();
    for (int s = 0; s < 128; s++)
      for (int k = 0; k < 8; k++) begin
        ord[s][k]  = k;
        mVld[s][k] = 1'b0;
      end
    mHit  = 0;
    mMiss = 0;
  endfunction

  function automatic logic [23:0] modelAgeVec(input int s);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[ord[s][k]*3 +: 3] = 3'(k);
    return v;
  endfunction

  // Re-place way p in the recency list of set s: at the front (MRU) or at the back (LRU).
  function automatic void moveWay(input int s, input int p, input bit toFront);
    int q[$];
    int idx;
    idx = 0;
    for (int k = 0; k < 8; k++) q.push_back(ord[s][k]);
    for (int k = 0; k < 8; k++) if (q[k] == p) idx = k;
    q.delete(idx);
    if (toFront) q.push_front(p);
    else         q.push_back(p);
    for (int k = 0; k < 8; k++) ord[s][k] = q[k];
  endfunction

  task automatic applyStimulus(input logic r, input logic [1:0] op, input int addr,
                               input logic [7:0] hw, input logic clr);
    bit hitInc, missInc, oneHot;
    int p, v;
    @(negedge clk);
    rst = r; opIn = op; addrIn = 7'(addr); hitWayIn = hw; cntClrIn = clr;
    hitInc = 0; missInc = 0;
    oneHot = ($countones(hw) == 1);
    p = 0;
    for (int k = 0; k < 8; k++) if (hw[k]) p = k;
    if (r) begin
      resetModel();
      expValid = 0; expErr = 0; expVictim = '0; expAge = '0;
    end else begin
      expValid = (op != NOP);
      expErr   = 0;
      if (op != NOP) begin
        expAge    = modelAgeVec(addr);
        expVictim = '0;
      end
      case (op)
        HIT: begin
          if (!oneHot || !mVld[addr][p]) expErr = 1;
          else begin
            moveWay(addr, p, 1);
            expVictim = hw;
            hitInc = 1;
          end
        end
        FILL: begin
          v = -1;
          for (int k = 7; k >= 0; k--) if (!mVld[addr][k]) v = k;
          if (v < 0) v = ord[addr][7];
          mVld[addr][v] = 1;
          moveWay(addr, v, 1);
          expVictim = 8'(1 << v);
          missInc = 1;
        end
        INV: begin
          if (!oneHot) expErr = 1;
          else begin
            moveWay(addr, p, 0);
            mVld[addr][p] = 0;
          end
        end
        default: ;
      endcase
    end
    if (clr || r) begin
      mHit = 0; mMiss = 0;
    end else begin
      if (hitInc  && mHit  < 64'hFFFF_FFFF) mHit++;
      if (missInc && mMiss < 64'hFFFF_FFFF) mMiss++;
    end
    @(posedge clk);
    #1;
    checkOutput("valid",    64'(validOut),   64'(expValid));
    checkOutput("err",      64'(errOut),     64'(expErr));
    checkOutput("victim",   64'(victimOut),  64'(expVictim));
    checkOutput("age_vec",  64'(ageVecOut),  64'(expAge));
    checkOutput("hit_cnt",  64'(hitCntOut),  64'(mHit));
    checkOutput("miss_cnt", 64'(missCntOut), 64'(mMiss));
  endtask

  initial begin
    logic [23:0] agesAfterFill;
    logic [7:0]  hwRand;
    rst = 1'b1; opIn = NOP; addrIn = '0; hitWayIn = '0; cntClrIn = 1'b0;
    sOp = NOP; sAddr = '0; sHitWay = '0; sCntClr = 1'b0;
    expVictim = '0; expAge = '0;
    resetModel();

    applyStimulus(1, NOP, 0, 8'h00, 0);

    // Eight fills of set 5 allocate ways 0..7 in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, FILL, 5, 8'h00, 0);
      checkOutput("fill_seq_victim", 64'(victimOut), 64'(1 << i));
    end
    checkOutput("fill_seq_miss_cnt", 64'(missCntOut), 64'd8);

    agesAfterFill = '0;
    for (int w = 0; w < 8; w++) agesAfterFill[w*3 +: 3] = 3'(7 - w);
    applyStimulus(0, HIT, 5, 8'h01, 0);
    checkOutput("hit_w0_victim", 64'(victimOut), 64'h01);
    checkOutput("hit_w0_ages",   64'(ageVecOut), 64'(agesAfterFill));
    applyStimulus(0, FILL, 5, 8'h00, 0);
    checkOutput("lru_victim",    64'(victimOut), 64'h02);
    checkOutput("lru_hit_cnt",   64'(hitCntOut), 64'd1);
    checkOutput("lru_miss_cnt",  64'(missCntOut), 64'd9);

    applyStimulus(0, INV, 5, 8'h08, 0);
    applyStimulus(0, FILL, 5, 8'h00, 0);
    checkOutput("inv_refill_victim", 64'(victimOut), 64'h08);

    applyStimulus(0, HIT, 9, 8'h00, 0);
    checkOutput("err_zero",      64'(errOut), 64'd1);
    applyStimulus(0, HIT, 9, 8'h18, 0);
    checkOutput("err_multi",     64'(errOut), 64'd1);
    applyStimulus(0, HIT, 9, 8'h04, 0);
    checkOutput("err_invalid",   64'(errOut), 64'd1);

    applyStimulus(0, HIT, 5, 8'h04, 0);
    applyStimulus(0, HIT, 5, 8'h10, 0);
    applyStimulus(0, HIT, 5, 8'h01, 1);
    checkOutput("clr_with_hit", 64'(hitCntOut), 64'd0);

    applyStimulus(1, HIT, 5, 8'h01, 0);
    applyStimulus(0, FILL, 77, 8'h00, 0);
    checkOutput("post_reset_victim", 64'(victimOut), 64'h01);

    // Randomized traffic over a few sets so hits, refills and evictions all occur.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 8) hwRand = 8'(1 << $urandom_range(0, 7));
      else                          hwRand = 8'($urandom);
      applyStimulus(($urandom_range(0, 249) == 0), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), hwRand, ($urandom_range(0, 24) == 0));
    end

    @(negedge clk);
    opIn = NOP; cntClrIn = 1'b0; rst = 1'b0;

    // Small configuration: four fills, then saturating hit counter.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sOp = FILL; sAddr = 4'd3;
      @(posedge clk);
      #1;
      checkOutput("small_fill_victim", 64'(sVictim), 64'(1 << i));
    end
    checkOutput("small_miss_cnt", 64'(sMissCnt), 64'd4);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      sOp = HIT; sHitWay = 4'b0001;
      @(posedge clk);
      #1;
      checkOutput("small_hit_sat", 64'(sHitCnt), 64'((k > 15) ? 15 : k));
    end
    @(negedge clk);
    sOp = NOP;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lru_buffer_param.md
Name: lru_buffer_param

Overview:
- Parametrised successor to the 8-way/128-set LRU state buffer.
- Holds true-LRU age state per set for a WAYS-way, SETS-set cache.
- Executes hit-promote, miss-allocate and invalidate operations, and reports the victim way and the pre-update age vector.
- Adds per-way valid bits (invalid ways preferred as victims), explicit op encoding in place of the gated clock, an error flag, and hit/miss counters.

Parameters:
- WAYS, 8, associativity; power of 2, >=2; AGE_W = log2(WAYS) derived.
- SETS, 128, number of sets; power of 2; AW = log2(SETS) derived.
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_op  in  2  0=NOP, 1=HIT, 2=MISS_FILL, 3=INVALIDATE
- i_addr  in  AW  set index
- i_hit_way  in  WAYS  one-hot way for HIT/INVALIDATE; ignored on MISS_FILL
- i_cnt_clr  in  1  synchronous clear of both counters
- o_valid  out  1  response valid, one cycle after a non-NOP op
- o_victim_way  out  WAYS  one-hot way written/promoted (MISS_FILL: chosen victim; HIT: i_hit_way; INVALIDATE: 0)
- o_age_vec  out  WAYS*AGE_W  ages of the addressed set before the update; way w at bits [w*AGE_W +: AGE_W]
- o_err  out  1  op rejected
- o_hit_cnt  out  CNT_W  saturating count of accepted HITs
- o_miss_cnt  out  CNT_W  saturating count of accepted MISS_FILLs

Behaviour:
- State per set: age[w] (AGE_W bits, 0 = MRU, WAYS-1 = LRU) and vld[w]. Ages of a set always form a permutation of 0..WAYS-1.
- Reset (at clk edge while rst=1):
  - every set gets age[w]=w and vld=0;
  - counters = 0;
  - o_valid, o_victim_way, o_age_vec, o_err = 0.
- Any op presented while rst=1 is discarded.
- Storage is flops. The state read is combinational from i_addr; update and output registers load on the same edge.
- Latency is 1 cycle. A back-to-back op to the same set sees the already-updated state, with no stall and no hazard.
- Promote(p), a = age[p]: every way with age < a increments; age[p] = 0; others unchanged.
- HIT:
  - Requires i_hit_way one-hot and vld[p]=1.
  - Effect: promote(p); hit_cnt += 1.
  - o_victim_way = i_hit_way.
- MISS_FILL:
  - Victim = lowest-index way with vld=0; if all ways are valid, the way with age == WAYS-1.
  - Effect: vld[victim] = 1; promote(victim); miss_cnt += 1.
  - o_victim_way = victim one-hot.
- INVALIDATE:
  - Requires i_hit_way one-hot. Invalidating an already-invalid way is legal and still reorders.
  - a = age[p]: every way with age > a decrements; age[p] = WAYS-1; vld[p] = 0.
  - o_victim_way = 0; counters unchanged.
- Error:
  - Raised by a HIT or INVALIDATE whose i_hit_way is zero or multi-hot, or by a HIT to an invalid way.
  - Effect: no state or counter change; o_valid=1, o_err=1, o_victim_way=0. o_age_vec still reports the set.
- NOP: o_valid=0; o_err=0; o_victim_way and o_age_vec hold their last value.
- Counters:
  - Saturate at all-ones.
  - i_cnt_clr has priority over an increment in the same cycle: result is 0.
  - Counter clearing is independent of rst.
- Set index wraps naturally: i_addr is exactly AW bits, so no out-of-range case exists.

Test Plan:
- Reset, then MISS_FILL x8 to set 5 -> victims 0x01,0x02,...,0x80 in order. After the 8th op, age of set 5 = {w7:0, w6:1, ..., w0:7}; miss_cnt=8.
- Continue: HIT way 0 (0x01) on set 5, then MISS_FILL set 5 -> HIT response victim=0x01; MISS_FILL victim=0x02 (way 1 is LRU); hit_cnt=1, miss_cnt=9.
- INVALIDATE way 3 (0x08) on set 5, then MISS_FILL set 5 -> next MISS_FILL victim=0x08 (invalid preferred over LRU); ages remain a permutation of 0..7.
- HIT with i_hit_way=0x00, then 0x18, then 0x04 on untouched set 9 -> o_err=1 on all three; no state or counter change.
- Back-to-back HITs to the same set on consecutive cycles -> second o_age_vec reflects the first update. Also: i_cnt_clr asserted together with a HIT -> hit_cnt=0.
- Assert rst for 1 cycle mid-stream with i_op=HIT -> all outputs 0 next cycle; next MISS_FILL to any set returns victim 0x01.
- Configuration WAYS=4, SETS=16 -> rerun the first scenario with 4 fills: victims 0x1,0x2,0x4,0x8; CNT_W=4 saturation after 15 hits.
